// File: rtl/gf180mcu_rr_merge2.sv
// Two-input round-robin stream merge with a registered output stage.
// S tags the held word with its source for a downstream mux2 select.
module gf180mcu_rr_merge2 #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [WIDTH-1:0] I0,
   input  logic             I0_VALID,
   output logic             I0_READY,
   input  logic [WIDTH-1:0] I1,
   input  logic             I1_VALID,
   output logic             I1_READY,
   output logic [WIDTH-1:0] Z,
   output logic             Z_VALID,
   input  logic             Z_READY,
   output logic             S
);

   logic load;
   logic last;
   logic pri0;
   logic pri1;
   logic g0;
   logic g1;

   // last == 1 means I1 went most recently, so I0 wins the next tie
   assign load = !Z_VALID || Z_READY;
   assign pri0 = !I1_VALID || last;
   assign pri1 = !I0_VALID || !last;
   assign g0   = I0_VALID && pri0;
   assign g1   = I1_VALID && pri1;

   assign I0_READY = RN && load && pri0;
   assign I1_READY = RN && load && pri1;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         Z       <= '0;
         Z_VALID <= 1'b0;
         S       <= 1'b0;
         last    <= 1'b1;
      end else if (load) begin
         if (g0) begin
            Z       <= I0;
            S       <= 1'b0;
            last    <= 1'b0;
            Z_VALID <= 1'b1;
         end else if (g1) begin
            Z       <= I1;
            S       <= 1'b1;
            last    <= 1'b1;
            Z_VALID <= 1'b1;
         end else begin
            Z_VALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gf180mcu_rr_merge2.sv
// Directed bench for gf180mcu_rr_merge2.
// Expected values are hand-derived from the round-robin rules.
module tb_gf180mcu_rr_merge2;

   logic       CLK;
   logic       RN;
   logic [7:0] I0;
   logic       I0_VALID;
   logic       I0_READY;
   logic [7:0] I1;
   logic       I1_VALID;
   logic       I1_READY;
   logic [7:0] Z;
   logic       Z_VALID;
   logic       Z_READY;
   logic       S;

   int n_tests = 0;
   int n_fail  = 0;

   gf180mcu_rr_merge2 #(.WIDTH(8)) dut (
      .CLK      (CLK),
      .RN       (RN),
      .I0       (I0),
      .I0_VALID (I0_VALID),
      .I0_READY (I0_READY),
      .I1       (I1),
      .I1_VALID (I1_VALID),
      .I1_READY (I1_READY),
      .Z        (Z),
      .Z_VALID  (Z_VALID),
      .Z_READY  (Z_READY),
      .S        (S)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [7:0] exp_z;
      RN       = 1'b0;
      I0       = 8'h11;
      I1       = 8'h22;
      I0_VALID = 1'b1;
      I1_VALID = 1'b1;
      Z_READY  = 1'b1;

      // reset held with both sources valid
      tick();
      tick();
      check("rst_i0_ready", I0_READY, 0);
      check("rst_i1_ready", I1_READY, 0);
      check("rst_z", Z, 0);
      check("rst_z_valid", Z_VALID, 0);
      check("rst_s", S, 0);

      RN = 1'b1;
      #1;
      check("rel_i0_ready", I0_READY, 1);
      check("rel_i1_ready", I1_READY, 0);

      // contention: strict alternation starting with I0
      for (int i = 0; i < 6; i++) begin
         tick();
         exp_z = (i % 2 == 0) ? 8'h11 : 8'h22;
         check("cont_z", Z, exp_z);
         check("cont_s", S, i % 2);
         check("cont_zv", Z_VALID, 1);
      end

      // single source I1
      I0_VALID = 1'b0;
      I1       = 8'h5a;
      #1;
      check("single_i1_ready", I1_READY, 1);
      tick();
      check("single_z", Z, 8'h5a);
      check("single_s", S, 1);
      check("single_zv", Z_VALID, 1);

      // idle cycles must not move priority
      I1_VALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle_zv", Z_VALID, 0);
      end
      check("idle_z_hold", Z, 8'h5a);
      check("idle_s_hold", S, 1);
      I0       = 8'h11;
      I1       = 8'h22;
      I0_VALID = 1'b1;
      I1_VALID = 1'b1;
      #1;
      check("hold_i0_ready", I0_READY, 1);
      check("hold_i1_ready", I1_READY, 0);
      tick();
      check("hold_z", Z, 8'h11);
      check("hold_s", S, 0);

      // backpressure on a held 0x33
      I0       = 8'h33;
      I1_VALID = 1'b0;
      tick();
      check("bp_load_z", Z, 8'h33);
      Z_READY  = 1'b0;
      I0       = 8'h44;
      I1       = 8'h55;
      I1_VALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_i0_ready", I0_READY, 0);
         check("bp_i1_ready", I1_READY, 0);
         tick();
         check("bp_z", Z, 8'h33);
         check("bp_s", S, 0);
         check("bp_zv", Z_VALID, 1);
      end

      // same-edge drain and fill
      I1_VALID = 1'b0;
      Z_READY  = 1'b1;
      #1;
      check("drain_i0_ready", I0_READY, 1);
      tick();
      check("drain_z", Z, 8'h44);
      check("drain_zv", Z_VALID, 1);
      check("drain_s", S, 0);

      // async reset between edges; LAST was 0 before it
      I0_VALID = 1'b0;
      #2;
      RN = 1'b0;
      #1;
      check("arst_zv", Z_VALID, 0);
      check("arst_z", Z, 0);
      check("arst_i0_ready", I0_READY, 0);
      #1;
      RN       = 1'b1;
      I0       = 8'h66;
      I1       = 8'h77;
      I0_VALID = 1'b1;
      I1_VALID = 1'b1;
      #1;
      check("arst_tie_i0_ready", I0_READY, 1);
      check("arst_tie_i1_ready", I1_READY, 0);
      tick();
      check("arst_tie_z", Z, 8'h66);
      check("arst_tie_s", S, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gf180mcu_rr_merge2.md
Name: gf180mcu_rr_merge2

Overview:
- Registered two-input stream merge that produces the select and data for a 2:1 mux stage.
- It arbitrates between two valid/ready sources, I0 and I1, using round-robin priority.
- The granted word is captured into a single output register with valid/ready flow control.
- S reports which source the held word came from, so a downstream mux2 stage can use it as its select.

Parameters:
- WIDTH, 8, data width of I0, I1 and Z (must be 1 or more).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RN  input  1  asynchronous active-low reset.
- I0  input  WIDTH  source-0 data.
- I0_VALID  input  1  source-0 word available.
- I0_READY  output  1  source-0 word accepted this cycle when I0_VALID is also high.
- I1  input  WIDTH  source-1 data.
- I1_VALID  input  1  source-1 word available.
- I1_READY  output  1  source-1 word accepted this cycle when I1_VALID is also high.
- Z  output  WIDTH  merged data (registered).
- Z_VALID  output  1  Z holds a word (registered).
- Z_READY  input  1  downstream accepts Z this cycle.
- S  output  1  source of the held Z: 0 = I0, 1 = I1 (registered).

Behaviour:
- Reset (RN low, asynchronous):
  - Z=0, Z_VALID=0, S=0, internal LAST=1, so I0 wins the first tie.
  - I0_READY=0 and I1_READY=0 while RN is low (readies are gated by RN).
  - Release takes effect at the first CLK edge with RN high.
- Reset mid-transfer: a held Z is discarded; no handshake completes in the cycle RN falls.
- LOAD = !Z_VALID || Z_READY (combinational). The output register is free, or is being emptied this cycle.
- Grant (combinational):
  - G0 = I0_VALID && (!I1_VALID || LAST==1)
  - G1 = I1_VALID && (!I0_VALID || LAST==0)
  - G0 and G1 are mutually exclusive.
- Readies:
  - I0_READY = RN && LAST-policy term, i.e. LOAD && (!I1_VALID || LAST==1).
  - I1_READY = RN && LOAD && (!I0_VALID || LAST==0).
  - Readies may depend on the other source's valid, but never on their own valid.
- Rising edge with LOAD and G0: Z<=I0, S<=0, LAST<=0, Z_VALID<=1.
- Rising edge with LOAD and G1: Z<=I1, S<=1, LAST<=1, Z_VALID<=1.
- Rising edge with LOAD and no grant: Z_VALID<=0. Z, S and LAST hold.
- Rising edge with !LOAD: Z, S, Z_VALID and LAST all hold. Both readies are 0 in this state (stall).
- Latency and throughput:
  - Latency is exactly 1 cycle from accept to Z_VALID.
  - Throughput is 1 word per cycle while Z_READY stays high.
- Simultaneous drain and fill: with Z_VALID=1, Z_READY=1 and a grant, the old word leaves and the new word loads on the same edge. There is no bubble.
- Fairness: with both sources continuously valid and Z_READY=1, grants strictly alternate.
  - Neither source waits more than 1 accepted word of the other.
- LAST changes only on an accepted transfer. Idle cycles and stalls do not move priority.
- Protocol obligations:
  - Sources must hold data and valid until accepted.
  - The block holds Z, S and Z_VALID stable while Z_VALID && !Z_READY.
- X on an input whose valid is low must not propagate to Z, S or the readies.

Test Plan:
- Reset then idle: RN low for 2 cycles with I0_VALID=I1_VALID=1 -> readies 0, Z=0, Z_VALID=0, S=0. After release, first accept is I0.
- Single source: I1_VALID=1 with I1=0x5A, I0_VALID=0, Z_READY=1 -> I1_READY=1. Next cycle Z=0x5A, S=1, Z_VALID=1.
- Contention: both valid continuously (I0=0x11, I1=0x22), Z_READY=1 for 6 cycles -> Z sequence 0x11,0x22,0x11,0x22,0x11,0x22 with S toggling 0,1,0,1,0,1.
- Backpressure: Z_VALID=1 with Z=0x33, Z_READY=0 for 3 cycles -> Z, S and Z_VALID stable, both readies 0. Z_READY=1 with I0 valid -> same-edge drain and load, no bubble.
- Priority hold over idle: I1 accepted, then 4 idle cycles, then both valid -> I0 granted first.
- Async reset mid-stream: RN pulsed low between edges while Z_VALID=1 -> Z_VALID drops immediately without a CLK edge. After release, LAST=1 and the next tie goes to I0.
